// File: rtl/rtype_ctrl.sv
// rtype_ctrl: multi-cycle R-type control (IDLE->DECODE->EXEC->WB); define RTYPE_SHIFT_EN to enable sll/srl/sra
module rtype_ctrl #(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [4:0]          a_addr,
    output logic [4:0]          b_addr,
    output logic [3:0]          alu_op,
    output logic [4:0]          shamt,
    input  logic [31:0]         alu_result,
    output logic [4:0]          w_addr,
    output logic [31:0]         w_data,
    output logic                reg_write,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    state_t state;
    logic [3:0] op;
    logic legal;
    logic [4:0] rs;
`ifdef RTYPE_SHIFT_EN
    logic shift;
    always_comb begin
        op = 4'd0;
        legal = instr[31:26] == 6'd0;
        shift = 1'b0;
        case (instr[5:0])
            6'h20: op = 4'd0;
            6'h21: op = 4'd1;
            6'h22: op = 4'd2;
            6'h23: op = 4'd3;
            6'h24: op = 4'd4;
            6'h25: op = 4'd5;
            6'h26: op = 4'd6;
            6'h27: op = 4'd7;
            6'h2A: op = 4'd8;
            6'h2B: op = 4'd9;
            6'h00: begin op = 4'hA; shift = 1'b1; end
            6'h02: begin op = 4'hB; shift = 1'b1; end
            6'h03: begin op = 4'hC; shift = 1'b1; end
            default: legal = 1'b0;
        endcase
        rs = shift ? 5'd0 : instr[25:21];
    end
`else
    always_comb begin
        op = 4'd0;
        legal = instr[31:26] == 6'd0;
        case (instr[5:0])
            6'h20: op = 4'd0;
            6'h21: op = 4'd1;
            6'h22: op = 4'd2;
            6'h23: op = 4'd3;
            6'h24: op = 4'd4;
            6'h25: op = 4'd5;
            6'h26: op = 4'd6;
            6'h27: op = 4'd7;
            6'h2A: op = 4'd8;
            6'h2B: op = 4'd9;
            default: legal = 1'b0;
        endcase
        rs = instr[25:21];
    end
    assign shamt = 5'd0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            instr_ready <= 1'b1;
            a_addr <= 5'd0;
            b_addr <= 5'd0;
            w_addr <= 5'd0;
            alu_op <= 4'd0;
`ifdef RTYPE_SHIFT_EN
            shamt <= 5'd0;
`endif
            w_data <= 32'd0;
            reg_write <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            illegal <= 1'b0;
            reg_write <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    state <= DECODE;
                    instr_ready <= 1'b0;
                    a_addr <= rs;
                    b_addr <= instr[20:16];
                    w_addr <= instr[15:11];
                    alu_op <= op;
                    illegal <= !legal;
`ifdef RTYPE_SHIFT_EN
                    shamt <= shift ? instr[10:6] : 5'd0;
`endif
                end
                DECODE: state <= illegal ? IDLE : EXEC;
                EXEC: begin
                    state <= WB;
                    w_data <= alu_result;
                    reg_write <= w_addr != 5'd0;
                    retired <= retired + 1'b1;
                end
                default: state <= IDLE;
            endcase
            // back to IDLE: reopen the handshake and park the reg_file/ALU selects at 0
            if (state == WB || (state == DECODE && illegal)) begin
                instr_ready <= 1'b1;
                a_addr <= 5'd0;
                b_addr <= 5'd0;
                w_addr <= 5'd0;
                alu_op <= 4'd0;
`ifdef RTYPE_SHIFT_EN
                shamt <= 5'd0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rtype_ctrl.sv
// tb_rtype_ctrl: directed vectors for rtype_ctrl against a reg_file with r[i]=i and a reference ALU
module tb_rtype_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] alu_result;
    logic instr_ready, reg_write, illegal;
    logic [4:0] a_addr, b_addr, shamt, w_addr;
    logic [3:0] alu_op;
    logic [31:0] w_data;
    logic [2:0] retired;
    logic [31:0] a_data, b_data;
    int checks = 0;
    int errors = 0;
    int exp_ret = 0;
    int n;

    rtype_ctrl #(.RETIRE_W(3)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .a_addr(a_addr), .b_addr(b_addr), .alu_op(alu_op),
        .shamt(shamt), .alu_result(alu_result), .w_addr(w_addr), .w_data(w_data),
        .reg_write(reg_write), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    assign a_data = {27'd0, a_addr};
    assign b_data = {27'd0, b_addr};
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'd0, 4'd1: alu_result = a_data + b_data;
            4'd2, 4'd3: alu_result = a_data - b_data;
            4'd4: alu_result = a_data & b_data;
            4'd5: alu_result = a_data | b_data;
            4'd6: alu_result = a_data ^ b_data;
            4'd7: alu_result = ~(a_data | b_data);
            4'd8: alu_result = {31'd0, $signed(a_data) < $signed(b_data)};
            4'd9: alu_result = {31'd0, a_data < b_data};
            4'hA: alu_result = b_data << shamt;
            4'hB: alu_result = b_data >> shamt;
            4'hC: alu_result = $signed(b_data) >>> shamt;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] w);
        instr = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_we", 32'(reg_write), 0);
        check("rst_ill", 32'(illegal), 0);
        check("rst_ret", 32'(retired), 0);
        check("rst_wdata", w_data, 0);
        check("rst_a", 32'(a_addr), 0);
        reset = 1'b0;
        // add $3,$1,$2
        issue(32'h00221820);
        check("add_a", 32'(a_addr), 1);
        check("add_b", 32'(b_addr), 2);
        check("add_op", 32'(alu_op), 0);
        check("add_w", 32'(w_addr), 3);
        check("add_busy", 32'(instr_ready), 0);
        step();
        check("add_exec_we", 32'(reg_write), 0);
        step();
        exp_ret = 1;
        check("add_we", 32'(reg_write), 1);
        check("add_waddr", 32'(w_addr), 3);
        check("add_wdata", w_data, 3);
        check("add_ret", 32'(retired), exp_ret % 8);
        step();
        check("add_idle_we", 32'(reg_write), 0);
        check("add_idle_ready", 32'(instr_ready), 1);
        check("add_idle_a", 32'(a_addr), 0);
        check("add_idle_w", 32'(w_addr), 0);
        check("add_hold_wdata", w_data, 3);
        // sub $4,$5,$1
        issue(32'h00A12022);
        check("sub_op", 32'(alu_op), 2);
        check("sub_a", 32'(a_addr), 5);
        check("sub_w", 32'(w_addr), 4);
        step();
        step();
        exp_ret = 2;
        check("sub_we", 32'(reg_write), 1);
        check("sub_wdata", w_data, 4);
        check("sub_ret", 32'(retired), exp_ret % 8);
        step();
        // add with rd=0: counted, never written
        issue(32'h00220020);
        check("rd0_we1", 32'(reg_write), 0);
        step();
        check("rd0_we2", 32'(reg_write), 0);
        step();
        exp_ret = 3;
        check("rd0_we3", 32'(reg_write), 0);
        check("rd0_ret", 32'(retired), exp_ret % 8);
        step();
        check("rd0_ready", 32'(instr_ready), 1);
        // lw: wrong opcode
        issue(32'h8C010000);
        check("lw_ill", 32'(illegal), 1);
        check("lw_we", 32'(reg_write), 0);
        step();
        check("lw_ready", 32'(instr_ready), 1);
        check("lw_ill_clr", 32'(illegal), 0);
        check("lw_ret", 32'(retired), exp_ret % 8);
        // unmapped funct (mult)
        issue(32'h00221818);
        check("mult_ill", 32'(illegal), 1);
        step();
        check("mult_ready", 32'(instr_ready), 1);
        // valid held high: one accept per 4 cycles
        n = 0;
        instr = 32'h00221820;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) n++;
            step();
        end
        instr_valid = 1'b0;
        exp_ret = 6;
        check("hold_accepts", 32'(n), 3);
        check("hold_ret", 32'(retired), exp_ret % 8);
        check("hold_ready", 32'(instr_ready), 1);
        // nor $6,$5,$1
        issue(32'h00A13027);
        check("nor_op", 32'(alu_op), 7);
        step();
        step();
        exp_ret = 7;
        check("nor_wdata", w_data, 32'hFFFFFFFA);
        check("nor_w", 32'(w_addr), 6);
        check("nor_ret", 32'(retired), exp_ret % 8);
        step();
        // slt $7,$1,$2; counter wraps 7 -> 0
        issue(32'h0022382A);
        check("slt_op", 32'(alu_op), 8);
        step();
        step();
        exp_ret = 8;
        check("slt_wdata", w_data, 1);
        check("slt_wrap", 32'(retired), exp_ret % 8);
        step();
        // reset during EXEC
        issue(32'h00221820);
        step();
        reset = 1'b1;
        step();
        exp_ret = 0;
        check("rexec_we", 32'(reg_write), 0);
        check("rexec_ready", 32'(instr_ready), 1);
        check("rexec_ret", 32'(retired), exp_ret % 8);
        reset = 1'b0;
        step();
        check("rexec_we2", 32'(reg_write), 0);
        check("rexec_ret2", 32'(retired), exp_ret % 8);
        // sll $6,$2,4
        issue(32'h00023100);
`ifdef RTYPE_SHIFT_EN
        check("sll_ill", 32'(illegal), 0);
        check("sll_op", 32'(alu_op), 10);
        check("sll_shamt", 32'(shamt), 4);
        check("sll_a", 32'(a_addr), 0);
        step();
        step();
        exp_ret = 1;
        check("sll_we", 32'(reg_write), 1);
        check("sll_wdata", w_data, 32);
        check("sll_ret", 32'(retired), exp_ret % 8);
        step();
        check("sll_shamt_clr", 32'(shamt), 0);
`else
        check("sll_ill", 32'(illegal), 1);
        check("sll_shamt", 32'(shamt), 0);
        step();
        check("sll_ready", 32'(instr_ready), 1);
        check("sll_ret", 32'(retired), exp_ret % 8);
`endif
        // all-zero word (nop)
        issue(32'h00000000);
`ifdef RTYPE_SHIFT_EN
        check("nop_ill", 32'(illegal), 0);
        step();
        step();
        exp_ret = 2;
        check("nop_we", 32'(reg_write), 0);
        check("nop_ret", 32'(retired), exp_ret % 8);
        step();
`else
        check("nop_ill", 32'(illegal), 1);
        step();
        check("nop_ready", 32'(instr_ready), 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
